// File: rtl/dm_port.sv
// rtl/dm_port.sv - M-stage data memory for the 5-stage MIPS pipeline
//
// Purpose:
//   Byte-addressed, little-endian data memory of DEPTH_WORDS 32-bit words.
//   Stores (sw/sh/sb) commit on the rising clock edge. Loads (lw/lh/lhu/lb/lbu)
//   return extended data combinationally. Misaligned accesses are flagged and
//   suppressed. Address bits above the word index are ignored, so addresses
//   wrap modulo 4*DEPTH_WORDS.
//
// Ports:
//   dm_clk_M_i    in   1   clock, all state changes on its rising edge
//   dm_clr_M_i    in   1   synchronous active-high clear of the whole array
//   dm_str_M_i    in  32   M-stage instruction word, opcode in [31:26]
//   dm_pc4_M_i    in  32   M-stage PC+4, only consumed by the write log
//   dm_alo_M_i    in  32   byte address (ALU result)
//   dm_rtd_M_i    in  32   store data (forwarded rt)
//   dm_rdata_M_o  out 32   extended load data, 0 for non-loads/misaligned
//   dm_we_M_o     out  1   a store commits at the next rising edge
//   dm_err_M_o    out  1   current load/store is misaligned

module dm_port #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_BITS   = 10
) (
  input  logic        dm_clk_M_i,
  input  logic        dm_clr_M_i,
  input  logic [31:0] dm_str_M_i,
  input  logic [31:0] dm_pc4_M_i,
  input  logic [31:0] dm_alo_M_i,
  input  logic [31:0] dm_rtd_M_i,
  output logic [31:0] dm_rdata_M_o,
  output logic        dm_we_M_o,
  output logic        dm_err_M_o
);

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  logic [31:0] r_mem [DEPTH_WORDS];

  logic [5:0]           w_op;
  logic [ADDR_BITS-1:0] w_idx;
  logic [1:0]           w_boff;
  logic [31:0]          w_word;
  logic                 w_is_load;
  logic                 w_is_store;
  logic                 w_need_word;
  logic                 w_need_half;
  logic                 w_misalign;
  logic                 w_store_ok;
  logic [31:0]          w_merged;
  logic [15:0]          w_half;
  logic [7:0]           w_byte;
  logic [31:0]          w_load;

  // PC+4, the upper address bits and the instruction fields below the opcode
  // are deliberately not used by the datapath.
  logic w_unused_bits;
  assign w_unused_bits = ^{dm_pc4_M_i, dm_alo_M_i[31:ADDR_BITS+2], dm_str_M_i[25:0]};

  assign w_op   = dm_str_M_i[31:26];
  assign w_idx  = dm_alo_M_i[ADDR_BITS+1:2];
  assign w_boff = dm_alo_M_i[1:0];
  assign w_word = r_mem[w_idx];

  // Opcode classification
  always_comb begin
    w_is_load   = 1'b0;
    w_is_store  = 1'b0;
    w_need_word = 1'b0;
    w_need_half = 1'b0;
    case (w_op)
      OP_LW:          begin w_is_load  = 1'b1; w_need_word = 1'b1; end
      OP_LH, OP_LHU:  begin w_is_load  = 1'b1; w_need_half = 1'b1; end
      OP_LB, OP_LBU:  w_is_load  = 1'b1;
      OP_SW:          begin w_is_store = 1'b1; w_need_word = 1'b1; end
      OP_SH:          begin w_is_store = 1'b1; w_need_half = 1'b1; end
      OP_SB:          w_is_store = 1'b1;
      default:        ;
    endcase
  end

  // Byte accesses can never be misaligned; halves need bit 0 clear, words both.
  assign w_misalign = (w_need_word && (w_boff != 2'b00)) ||
                      (w_need_half && w_boff[0]);

  assign dm_err_M_o = (w_is_load || w_is_store) && w_misalign;
  assign w_store_ok = w_is_store && !w_misalign;
  assign dm_we_M_o  = w_store_ok && !dm_clr_M_i;

  // Read-modify-write merge: unselected bytes keep their current value.
  always_comb begin
    w_merged = w_word;
    case (w_op)
      OP_SW: w_merged = dm_rtd_M_i;
      OP_SH: begin
        if (w_boff[1]) w_merged[31:16] = dm_rtd_M_i[15:0];
        else           w_merged[15:0]  = dm_rtd_M_i[15:0];
      end
      OP_SB: begin
        case (w_boff)
          2'd0:    w_merged[7:0]   = dm_rtd_M_i[7:0];
          2'd1:    w_merged[15:8]  = dm_rtd_M_i[7:0];
          2'd2:    w_merged[23:16] = dm_rtd_M_i[7:0];
          default: w_merged[31:24] = dm_rtd_M_i[7:0];
        endcase
      end
      default: ;
    endcase
  end

  // Clear has priority: a store in the same cycle is dropped.
  always_ff @(posedge dm_clk_M_i) begin
    if (dm_clr_M_i) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_store_ok) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  // Load lane selection and extension
  always_comb begin
    w_half = w_boff[1] ? w_word[31:16] : w_word[15:0];
    case (w_boff)
      2'd0:    w_byte = w_word[7:0];
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
  end

  always_comb begin
    w_load = '0;
    case (w_op)
      OP_LW:   w_load = w_word;
      OP_LH:   w_load = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_load = {16'h0000, w_half};
      OP_LB:   w_load = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_load = {24'h000000, w_byte};
      default: w_load = '0;
    endcase
  end

  assign dm_rdata_M_o = (w_is_load && !w_misalign) ? w_load : 32'h0000_0000;

endmodule

// File: tb/tb_dm_port.sv
// tb/tb_dm_port.sv - directed self-checking bench for dm_port
module tb_dm_port;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_ADD = 6'b000000;

  logic        clk;
  logic        clr;
  logic [31:0] str;
  logic [31:0] pc4;
  logic [31:0] alo;
  logic [31:0] rtd;
  logic [31:0] rdata;
  logic        we;
  logic        err;

  int n_checks;
  int n_errors;

  dm_port #(.DEPTH_WORDS(1024), .ADDR_BITS(10)) dut (
    .dm_clk_M_i   (clk),
    .dm_clr_M_i   (clr),
    .dm_str_M_i   (str),
    .dm_pc4_M_i   (pc4),
    .dm_alo_M_i   (alo),
    .dm_rtd_M_i   (rtd),
    .dm_rdata_M_o (rdata),
    .dm_we_M_o    (we),
    .dm_err_M_o   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write log for committed stores, printed once the edge has updated memory.
  always @(posedge clk) begin
    logic [31:0] l_pc;
    logic [31:0] l_addr;
    logic [9:0]  l_idx;
    if (we) begin
      l_pc   = pc4 - 32'd4;
      l_addr = {alo[31:2], 2'b00};
      l_idx  = alo[11:2];
      #1;
      $display("@%h: *%h <= %h", l_pc, l_addr, dut.r_mem[l_idx]);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present an access mid-cycle so outputs settle well away from the edge.
  task automatic drive(input logic [5:0] op, input logic [31:0] addr,
                       input logic [31:0] data, input logic c);
    @(posedge clk);
    #2;
    str = {op, 26'h0};
    alo = addr;
    rtd = data;
    clr = c;
    pc4 = pc4 + 32'd4;
    #2;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clr = 1'b1;
    str = '0;
    pc4 = 32'h0040_0000;
    alo = '0;
    rtd = '0;
    @(posedge clk);
    @(posedge clk);

    // Reset state
    drive(OP_LW, 32'h0, 32'h0, 1'b0);
    check_eq("rst_lw_rdata", rdata, 32'h0);
    check_eq("rst_lw_err", {31'h0, err}, 32'h0);
    check_eq("rst_lw_we", {31'h0, we}, 32'h0);

    // sw then lw
    drive(OP_SW, 32'h10, 32'h1234_5678, 1'b0);
    check_eq("sw_we", {31'h0, we}, 32'h1);
    check_eq("sw_err", {31'h0, err}, 32'h0);
    drive(OP_LW, 32'h10, 32'h0, 1'b0);
    check_eq("lw_10", rdata, 32'h1234_5678);

    // sb merge, signed/unsigned byte loads
    drive(OP_SB, 32'h12, 32'hFFFF_FFAB, 1'b0);
    check_eq("sb_we", {31'h0, we}, 32'h1);
    drive(OP_LW, 32'h10, 32'h0, 1'b0);
    check_eq("sb_merge", rdata, 32'h12AB_5678);
    drive(OP_LB, 32'h12, 32'h0, 1'b0);
    check_eq("lb_12", rdata, 32'hFFFF_FFAB);
    drive(OP_LBU, 32'h12, 32'h0, 1'b0);
    check_eq("lbu_12", rdata, 32'h0000_00AB);
    drive(OP_LB, 32'h10, 32'h0, 1'b0);
    check_eq("lb_10", rdata, 32'h0000_0078);

    // sh upper half, half loads
    drive(OP_SH, 32'h22, 32'h5555_8001, 1'b0);
    check_eq("sh_we", {31'h0, we}, 32'h1);
    drive(OP_LH, 32'h22, 32'h0, 1'b0);
    check_eq("lh_22", rdata, 32'hFFFF_8001);
    drive(OP_LHU, 32'h22, 32'h0, 1'b0);
    check_eq("lhu_22", rdata, 32'h0000_8001);
    drive(OP_LW, 32'h20, 32'h0, 1'b0);
    check_eq("lw_20", rdata, 32'h8001_0000);

    // Misaligned store and load
    drive(OP_SW, 32'h13, 32'hFFFF_FFFF, 1'b0);
    check_eq("sw13_err", {31'h0, err}, 32'h1);
    check_eq("sw13_we", {31'h0, we}, 32'h0);
    drive(OP_LW, 32'h10, 32'h0, 1'b0);
    check_eq("sw13_nochg", rdata, 32'h12AB_5678);
    drive(OP_LH, 32'h11, 32'h0, 1'b0);
    check_eq("lh11_err", {31'h0, err}, 32'h1);
    check_eq("lh11_rdata", rdata, 32'h0);
    drive(OP_SH, 32'h21, 32'h0000_1111, 1'b0);
    check_eq("sh21_err", {31'h0, err}, 32'h1);
    check_eq("sh21_we", {31'h0, we}, 32'h0);
    drive(OP_LW, 32'h20, 32'h0, 1'b0);
    check_eq("sh21_nochg", rdata, 32'h8001_0000);

    // Non-memory opcode
    drive(OP_ADD, 32'h10, 32'h0, 1'b0);
    check_eq("nop_rdata", rdata, 32'h0);
    check_eq("nop_we", {31'h0, we}, 32'h0);
    check_eq("nop_err", {31'h0, err}, 32'h0);

    // Clear beats a same-cycle store
    drive(OP_SW, 32'h4, 32'hDEAD_BEEF, 1'b1);
    check_eq("clr_sw_we", {31'h0, we}, 32'h0);
    drive(OP_LW, 32'h4, 32'h0, 1'b0);
    check_eq("clr_lw_4", rdata, 32'h0);
    drive(OP_LW, 32'h10, 32'h0, 1'b0);
    check_eq("clr_lw_10", rdata, 32'h0);

    // Address wrap: 0x1004 aliases 0x4
    drive(OP_SW, 32'h1004, 32'hCAFE_F00D, 1'b0);
    check_eq("wrap_we", {31'h0, we}, 32'h1);
    drive(OP_LW, 32'h4, 32'h0, 1'b0);
    check_eq("wrap_lw_4", rdata, 32'hCAFE_F00D);
    drive(OP_LB, 32'h7, 32'h0, 1'b0);
    check_eq("lb_7", rdata, 32'hFFFF_FFCA);
    drive(OP_LHU, 32'h6, 32'h0, 1'b0);
    check_eq("lhu_6", rdata, 32'h0000_CAFE);
    drive(OP_LH, 32'h4, 32'h0, 1'b0);
    check_eq("lh_4", rdata, 32'hFFFF_F00D);

    drive(OP_ADD, 32'h0, 32'h0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
